// File: rtl/mux_rr_stage.sv
// Registered N-channel mux stage with fixed-select or round-robin arbitration,
// valid/ready on every input and a one-deep output register.
module mux_rr_stage #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] chan_data [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic            grant_valid;
    logic [SELW-1:0] grant_idx;
    logic [SELW-1:0] scan_idx;
    logic            load_en;
    logic            xfer;

    // Scan farthest-first so the nearest valid channel after ptr wins; ptr itself is last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        if (!mode) begin
            grant_valid = in_valid[sel];
            grant_idx   = sel;
        end else begin
            for (int k = CHANNELS; k >= 1; k--) begin
                scan_idx = ptr_q + SELW'(k);
                if (in_valid[scan_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
    end

    assign load_en  = !out_valid_q || out_ready;
    assign xfer     = grant_valid && load_en && !rst;
    assign in_ready = xfer ? (CHANNELS'(1) << grant_idx) : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = chan_data[grant_idx];
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            ptr_d       = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SELW'(CHANNELS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_stage.sv
// Self-checking bench for mux_rr_stage: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_mux_rr_stage;

    localparam int W = 4;
    localparam int C = 4;
    localparam int S = 2;

    logic           clk;
    logic           rst;
    logic           mode;
    logic [S-1:0]   sel;
    logic [C*W-1:0] in_data;
    logic [C-1:0]   in_valid;
    logic [C-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_chan;
    logic           out_valid;
    logic           out_ready;

    mux_rr_stage #(
        .WIDTH    (W),
        .CHANNELS (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: state as plain integers.
    bit m_init  = 0;
    bit m_valid = 0;
    int m_data  = 0;
    int m_chan  = 0;
    int m_ptr   = C - 1;

    // Channel whose circular distance past ptr is smallest wins; -1 means none.
    function automatic int exp_grant(input logic md, input int s, input logic [C-1:0] v,
                                     input int p);
        int best;
        int bestd;
        best  = -1;
        bestd = C;
        if (!md) return v[s] ? s : -1;
        for (int i = 0; i < C; i++) begin
            if (v[i]) begin
                int d;
                d = (i - p - 1 + 2 * C) % C;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic int exp_ready();
        int g;
        g = exp_grant(mode, int'(sel), in_valid, m_ptr);
        if (rst || g < 0 || (m_valid && !out_ready)) return 0;
        return 1 << g;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("m_in_ready", 32'(in_ready), 32'(exp_ready()));
                chk("m_out_valid", 32'(out_valid), 32'(m_valid));
                chk("m_out_data", 32'(out_data), 32'(m_data));
                chk("m_out_chan", 32'(out_chan), 32'(m_chan));
            end
            @(posedge clk);
            if (rst) begin
                m_init  = 1;
                m_valid = 0;
                m_data  = 0;
                m_chan  = 0;
                m_ptr   = C - 1;
            end else if (m_init) begin
                int g;
                g = exp_grant(mode, int'(sel), in_valid, m_ptr);
                if (g >= 0 && (!m_valid || out_ready)) begin
                    m_valid = 1;
                    m_data  = int'(in_data[g*W +: W]);
                    m_chan  = g;
                    m_ptr   = g;
                end else if (out_ready) begin
                    m_valid = 0;
                end
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk_out(input string name, input int ch, input int data, input bit v);
        chk({name, "_chan"}, 32'(out_chan), 32'(ch));
        chk({name, "_data"}, 32'(out_data), 32'(data));
        chk({name, "_valid"}, 32'(out_valid), 32'(v));
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = 16'hDCBA;

        nxt();
        nxt();
        chk_out("reset", 0, 0, 1'b0);
        chk("reset_in_ready", 32'(in_ready), 32'h0);
        #1 rst = 1'b0;
        #1 chk("first_ready", 32'(in_ready), 32'b0001);

        // Round-robin rotation; last edge switches to sparse 1010 with ptr = 3.
        for (int i = 0; i < 8; i++) begin
            nxt();
            chk_out("rotate", i % 4, 10 + i % 4, 1'b1);
            if (i == 7) #1 in_valid = 4'b1010;
        end
        nxt(); chk_out("wrap0", 1, 4'hB, 1'b1);
        nxt(); chk_out("wrap1", 3, 4'hD, 1'b1);
        nxt(); chk_out("wrap2", 1, 4'hB, 1'b1);

        #1;
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1 chk("fixed_ready", 32'(in_ready), 32'b0100);
            nxt();
            chk_out("fixed", 2, 4'hC, 1'b1);
        end
        #1 in_valid = 4'b1011;
        #1 chk("fixed_off_ready", 32'(in_ready), 32'h0);
        nxt();
        chk("fixed_drop_valid", 32'(out_valid), 32'h0);

        // Back-pressure: ptr = 2, so channel 3 loads, then is held.
        #1;
        mode     = 1'b1;
        in_valid = 4'b1111;
        nxt();
        chk_out("bp_load", 3, 4'hD, 1'b1);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", 32'(in_ready), 32'h0);
            nxt();
            chk_out("bp_hold", 3, 4'hD, 1'b1);
        end
        #1 out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'b0001);
        nxt();
        chk_out("bp_next", 0, 4'hA, 1'b1);
        nxt();
        chk_out("pre_rst", 1, 4'hB, 1'b1);

        #1 rst = 1'b1;
        nxt();
        chk_out("mid_rst", 0, 0, 1'b0);
        #1 rst = 1'b0;
        #1 chk("post_rst_ready", 32'(in_ready), 32'b0001);
        nxt();
        chk_out("post_rst", 0, 4'hA, 1'b1);

        for (int n = 0; n < 2000; n++) begin
            #1;
            rst       = ($urandom_range(0, 49) == 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            nxt();
        end

        #1;
        rst = 1'b0;
        nxt();
        nxt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
